// File: rtl/dec_calc_pkg.sv
// Shared types and helpers for the keypad digit accumulator.
package dec_calc_pkg;

  localparam int NUM_KEYS = 10;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ENTRY,
    ST_FULL
  } entry_state_t;

  function automatic logic [3:0] popcount10(input logic [NUM_KEYS-1:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/dec_digit_accumulator_key_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector per bit.
module key_edge_sync #(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] raw,
  output logic [N-1:0] rise
);

  logic [N-1:0] s1;
  logic [N-1:0] s2;
  logic [N-1:0] s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Pulse is combinational; the consumer's register is the third cycle of latency.
  assign rise = s2 & ~s3;

endmodule

// File: rtl/dec_digit_accumulator.sv
// Keypad-to-binary operand entry with overflow/count limits and a valid/ready output.
module dec_digit_accumulator
  import dec_calc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_KEYS-1:0]              key,
  input  logic                             enter,
  input  logic                             clear,
  output logic [WIDTH-1:0]                 res,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [WIDTH-1:0]                 acc,
  output logic [$clog2(MAX_DIGITS+1)-1:0]  ndigits,
  output logic                             ovf,
  output logic                             multi_err
);

  localparam int NDW = $clog2(MAX_DIGITS+1);

  logic [NUM_KEYS+1:0] edges;
  logic [NUM_KEYS-1:0] dig_e;
  logic                ent_e;
  logic                clr_e;
  logic [3:0]          cnt;
  logic [3:0]          d;
  logic [WIDTH+3:0]    nxt;
  logic                accept;
  entry_state_t        state, state_n;
  logic [WIDTH-1:0]    acc_n, res_n;
  logic [NDW-1:0]      nd_n;
  logic                ovf_n, rv_n, merr_n;

  key_edge_sync #(.N(NUM_KEYS+2)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   ({clear, enter, key}),
    .rise  (edges)
  );

  assign dig_e = edges[NUM_KEYS-1:0];
  assign ent_e = edges[NUM_KEYS];
  assign clr_e = edges[NUM_KEYS+1];
  assign cnt   = popcount10(dig_e);

  always_comb begin
    d = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (dig_e[i]) d = 4'(i);
    end
  end

  // acc*10 + d in four extra bits so an out-of-range result is visible, never wrapped.
  assign nxt = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + {{WIDTH{1'b0}}, d};

  assign accept = (state != ST_FULL) && (ndigits < NDW'(MAX_DIGITS)) &&
                  (nxt[WIDTH+3:WIDTH] == '0);

  always_comb begin
    acc_n   = acc;
    nd_n    = ndigits;
    ovf_n   = ovf;
    state_n = state;
    res_n   = res;
    rv_n    = res_valid;
    merr_n  = 1'b0;
    if (res_valid && res_ready) rv_n = 1'b0;
    if (clr_e) begin
      acc_n   = '0;
      nd_n    = '0;
      ovf_n   = 1'b0;
      state_n = ST_EMPTY;
    end else if (cnt > 4'd1) begin
      merr_n = 1'b1;
    end else begin
      if (cnt == 4'd1) begin
        if (accept) begin
          acc_n   = nxt[WIDTH-1:0];
          nd_n    = ndigits + NDW'(1);
          state_n = ST_ENTRY;
        end else begin
          ovf_n   = 1'b1;
          state_n = ST_FULL;
        end
      end
      // Commit sees the post-digit value so digit+enter in one cycle folds first.
      if (ent_e && (!res_valid || res_ready)) begin
        res_n   = acc_n;
        rv_n    = 1'b1;
        acc_n   = '0;
        nd_n    = '0;
        ovf_n   = 1'b0;
        state_n = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      ndigits   <= '0;
      ovf       <= 1'b0;
      state     <= ST_EMPTY;
      res       <= '0;
      res_valid <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      acc       <= acc_n;
      ndigits   <= nd_n;
      ovf       <= ovf_n;
      state     <= state_n;
      res       <= res_n;
      res_valid <= rv_n;
      multi_err <= merr_n;
    end
  end

endmodule

// File: tb/tb_dec_digit_accumulator.sv
// Directed bench for dec_digit_accumulator at WIDTH=8, MAX_DIGITS=3.
module tb_dec_digit_accumulator;

  logic       clk;
  logic       rst_n;
  logic [9:0] key;
  logic       enter;
  logic       clear;
  logic [7:0] res;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] acc;
  logic [1:0] ndigits;
  logic       ovf;
  logic       multi_err;

  int n_checks;
  int n_fail;

  dec_digit_accumulator #(.WIDTH(8), .MAX_DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .enter     (enter),
    .clear     (clear),
    .res       (res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .acc       (acc),
    .ndigits   (ndigits),
    .ovf       (ovf),
    .multi_err (multi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise the key, wait for the action to land (3 clocks), release and let it drain.
  task automatic press_digit(input int k);
    key[k] = 1'b1;
    tick(3);
    key[k] = 1'b0;
    tick(3);
  endtask

  task automatic press_enter;
    enter = 1'b1;
    tick(3);
  endtask

  task automatic release_enter;
    enter = 1'b0;
    tick(3);
  endtask

  task automatic press_clear;
    clear = 1'b1;
    tick(3);
    clear = 1'b0;
    tick(3);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    key       = '0;
    enter     = 1'b0;
    clear     = 1'b0;
    res_ready = 1'b1;
    tick(2);
    check("rst_res", res, 0);
    check("rst_valid", res_valid, 0);
    check("rst_acc", acc, 0);
    check("rst_nd", ndigits, 0);
    check("rst_ovf", ovf, 0);
    check("rst_merr", multi_err, 0);
    rst_n = 1'b1;
    tick(2);

    // 1: 1,2,7 then enter
    press_digit(1); check("t1_acc1", acc, 1);
    press_digit(2); check("t1_acc12", acc, 12);
    press_digit(7); check("t1_acc127", acc, 127);
    check("t1_nd3", ndigits, 3);
    press_enter;
    check("t1_res", res, 127);
    check("t1_valid", res_valid, 1);
    check("t1_acc0", acc, 0);
    check("t1_nd0", ndigits, 0);
    release_enter;
    check("t1_consumed", res_valid, 0);

    // 2: width overflow at 256
    press_digit(2); press_digit(5);
    check("t2_acc25", acc, 25);
    press_digit(6);
    check("t2_acc_hold", acc, 25);
    check("t2_ovf", ovf, 1);
    check("t2_nd", ndigits, 2);
    press_digit(1);
    check("t2_full_hold", acc, 25);
    press_enter;
    check("t2_res", res, 25);
    check("t2_ovf_clr", ovf, 0);
    release_enter;

    // 3: digit-count limit
    press_digit(0); press_digit(0); press_digit(1);
    check("t3_acc1", acc, 1);
    press_digit(2);
    check("t3_acc_hold", acc, 1);
    check("t3_nd3", ndigits, 3);
    check("t3_ovf", ovf, 1);
    press_clear;
    check("t3_clr_acc", acc, 0);
    check("t3_clr_ovf", ovf, 0);
    check("t3_clr_nd", ndigits, 0);

    // 4: simultaneous keys, then a long hold
    key[3] = 1'b1; key[4] = 1'b1;
    tick(3);
    check("t4_merr", multi_err, 1);
    check("t4_acc", acc, 0);
    tick(1);
    check("t4_merr_pulse", multi_err, 0);
    key = '0;
    tick(3);
    key[5] = 1'b1;
    tick(20);
    check("t4_hold_acc", acc, 5);
    check("t4_hold_nd", ndigits, 1);
    key[5] = 1'b0;
    tick(3);
    press_clear;

    // 5: back-pressure
    res_ready = 1'b0;
    press_digit(9);
    press_enter;
    check("t5_res9", res, 9);
    check("t5_valid", res_valid, 1);
    release_enter;
    press_digit(4); press_digit(2);
    press_enter;
    check("t5_res_held", res, 9);
    check("t5_acc_kept", acc, 42);
    check("t5_nd_kept", ndigits, 2);
    check("t5_valid_held", res_valid, 1);
    release_enter;
    res_ready = 1'b1;
    tick(1);
    check("t5_drop", res_valid, 0);
    press_enter;
    check("t5_res42", res, 42);
    check("t5_acc0", acc, 0);
    release_enter;

    // 6: clear beats digit; async reset mid-entry
    press_digit(1); press_digit(2);
    check("t6_acc12", acc, 12);
    clear = 1'b1; key[7] = 1'b1;
    tick(3);
    check("t6_clr_acc", acc, 0);
    check("t6_clr_nd", ndigits, 0);
    clear = 1'b0; key[7] = 1'b0;
    tick(3);
    check("t6_no_late_digit", acc, 0);
    press_digit(3);
    check("t6_acc3", acc, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_arst_acc", acc, 0);
    check("t6_arst_nd", ndigits, 0);
    check("t6_arst_res", res, 0);
    check("t6_arst_valid", res_valid, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
